// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the ALU and the load/store
// buffer. Each source has its own small result FIFO; a round-robin arbiter picks
// one FIFO head per cycle and broadcasts it on a registered CDB. A rollback
// empties both FIFOs, and rdy=0 freezes the whole block.
module cdb_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ROB_POS_W = 4,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 alu_valid,
   output logic                 alu_ready,
   input  logic [ROB_POS_W-1:0] alu_rob_pos,
   input  logic [DATA_W-1:0]    alu_val,
   input  logic                 lsb_valid,
   output logic                 lsb_ready,
   input  logic [ROB_POS_W-1:0] lsb_rob_pos,
   input  logic [DATA_W-1:0]    lsb_val,
   output logic                 cdb_valid,
   output logic                 cdb_src,
   output logic [ROB_POS_W-1:0] cdb_rob_pos,
   output logic [DATA_W-1:0]    cdb_val
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ROB_POS_W + DATA_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [ENT_W-1:0] r_aluMem [DEPTH];
   logic [ENT_W-1:0] r_lsbMem [DEPTH];
   logic [PTR_W-1:0] r_aluWr, r_aluRd, r_lsbWr, r_lsbRd;
   logic [CNT_W-1:0] r_aluCnt, r_lsbCnt;
   logic             r_lastGrant;

   logic             w_advance;
   logic             w_aluPush, w_lsbPush;
   logic             w_aluNonEmpty, w_lsbNonEmpty;
   logic             w_grantAlu, w_grantLsb;
   logic [ENT_W-1:0] w_aluHead, w_lsbHead;

   // Handshake, arbitration and head selection, all from registered state
   always_comb begin
      w_advance     = rdy && !rollback;
      alu_ready     = (r_aluCnt < FULL_CNT);
      lsb_ready     = (r_lsbCnt < FULL_CNT);
      w_aluPush     = alu_valid && alu_ready;
      w_lsbPush     = lsb_valid && lsb_ready;
      w_aluNonEmpty = (r_aluCnt != '0);
      w_lsbNonEmpty = (r_lsbCnt != '0);
      // On a tie the source that did not win last time gets the bus
      w_grantAlu    = w_aluNonEmpty && (!w_lsbNonEmpty || r_lastGrant);
      w_grantLsb    = w_lsbNonEmpty && (!w_aluNonEmpty || !r_lastGrant);
      w_aluHead     = r_aluMem[r_aluRd];
      w_lsbHead     = r_lsbMem[r_lsbRd];
   end

   // FIFO storage: write accepted results at the tail; contents need no reset
   always_ff @(posedge clk) begin
      if (rst_n && w_advance) begin
         if (w_aluPush) r_aluMem[r_aluWr] <= {alu_rob_pos, alu_val};
         if (w_lsbPush) r_lsbMem[r_lsbWr] <= {lsb_rob_pos, lsb_val};
      end
   end

   // FIFO pointers and occupancy; rollback clears both queues
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_aluWr  <= '0;
         r_aluRd  <= '0;
         r_aluCnt <= '0;
         r_lsbWr  <= '0;
         r_lsbRd  <= '0;
         r_lsbCnt <= '0;
      end else if (rdy) begin
         if (rollback) begin
            r_aluWr  <= '0;
            r_aluRd  <= '0;
            r_aluCnt <= '0;
            r_lsbWr  <= '0;
            r_lsbRd  <= '0;
            r_lsbCnt <= '0;
         end else begin
            if (w_aluPush)  r_aluWr <= r_aluWr + PTR_ONE;
            if (w_grantAlu) r_aluRd <= r_aluRd + PTR_ONE;
            if (w_lsbPush)  r_lsbWr <= r_lsbWr + PTR_ONE;
            if (w_grantLsb) r_lsbRd <= r_lsbRd + PTR_ONE;
            case ({w_aluPush, w_grantAlu})
               2'b10:   r_aluCnt <= r_aluCnt + CNT_ONE;
               2'b01:   r_aluCnt <= r_aluCnt - CNT_ONE;
               default: r_aluCnt <= r_aluCnt;
            endcase
            case ({w_lsbPush, w_grantLsb})
               2'b10:   r_lsbCnt <= r_lsbCnt + CNT_ONE;
               2'b01:   r_lsbCnt <= r_lsbCnt - CNT_ONE;
               default: r_lsbCnt <= r_lsbCnt;
            endcase
         end
      end
   end

   // Registered broadcast: the granted head goes out for exactly one cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cdb_valid   <= 1'b0;
         cdb_src     <= 1'b0;
         cdb_rob_pos <= '0;
         cdb_val     <= '0;
         r_lastGrant <= 1'b1;
      end else if (rdy) begin
         if (rollback) begin
            cdb_valid <= 1'b0;
         end else if (w_grantAlu) begin
            cdb_valid                <= 1'b1;
            cdb_src                  <= 1'b0;
            {cdb_rob_pos, cdb_val}   <= w_aluHead;
            r_lastGrant              <= 1'b0;
         end else if (w_grantLsb) begin
            cdb_valid                <= 1'b1;
            cdb_src                  <= 1'b1;
            {cdb_rob_pos, cdb_val}   <= w_lsbHead;
            r_lastGrant              <= 1'b1;
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

`ifndef SYNTHESIS
   // Occupancy can never exceed the FIFO depth
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (r_aluCnt <= FULL_CNT);
         assert (r_lsbCnt <= FULL_CNT);
      end
   end
`endif

endmodule
